// File: rtl/sdr_wb_pkg.sv
// Shared constants and state type for the Wishbone master
// that feeds the SDRAM controller slave port.
package sdr_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    BUS
  } wbm_state_t;

endpackage

// File: rtl/wb_ack_timeout.sv
// Per-beat ack watchdog: counts cycles with stb high and no ack,
// pulses expire on the cycle the count would reach TIMEOUT.
module wb_ack_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Fires during the TIMEOUT-th stb cycle so the abort shows next cycle
  assign expire = run & ~clr & (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (clr || expire) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_sdr_master.sv
// Wishbone burst master: command stream in, incrementing bursts out,
// read beats returned on a response stream, ack timeout abort.
module wb_sdr_master
  import sdr_wb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [dw/8-1:0]   cmd_sel,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [dw-1:0]     wdat,
  output logic              rsp_valid,
  output logic [dw-1:0]     rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_i,
  output logic              wb_stb_i,
  output logic              wb_we_i,
  output logic [APP_AW-1:0] wb_addr_i,
  output logic [dw-1:0]     wb_dat_i,
  output logic [dw/8-1:0]   wb_sel_i,
  output logic [2:0]        wb_cti_i,
  input  logic              wb_ack_o,
  input  logic [dw-1:0]     wb_dat_o
);

  localparam int BW = dw / 8;

  wbm_state_t r_state, w_next;

  logic              r_we;
  logic              r_single;
  logic              r_full;
  logic [APP_AW-1:0] r_addr;
  logic [BW-1:0]     r_sel;
  logic [LEN_W-1:0]  r_rem;
  logic [dw-1:0]     r_wdat;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic [dw-1:0]     r_rsp_data;
  logic              r_done;
  logic              r_err;

  logic w_bus;
  logic w_stb;
  logic w_ack;
  logic w_last;
  logic w_accept;
  logic w_wtake;
  logic w_expire;

  assign w_bus    = (r_state == BUS);
  assign w_stb    = w_bus & (~r_we | r_full);
  assign w_ack    = w_stb & wb_ack_o;
  assign w_last   = (r_rem == LEN_W'(1));
  assign w_accept = cmd_valid & cmd_ready;
  assign w_wtake  = wdat_valid & wdat_ready;

  wb_ack_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .run      (w_stb),
    .clr      (~w_bus | w_ack),
    .expire   (w_expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= WAIT_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    unique case (r_state)
      WAIT_INIT: begin
        if (sdr_init_done) w_next = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = BUS;
      end
      BUS: begin
        if ((w_ack && w_last) || w_expire) w_next = IDLE;
      end
      default: w_next = WAIT_INIT;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we        <= 1'b0;
      r_single    <= 1'b0;
      r_full      <= 1'b0;
      r_addr      <= '0;
      r_sel       <= '0;
      r_rem       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_we     <= cmd_we;
        r_addr   <= cmd_addr & ~APP_AW'(BW - 1);
        r_sel    <= cmd_sel;
        r_rem    <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
        r_single <= (cmd_len <= LEN_W'(1));
        r_full   <= 1'b0;
      end
      if (w_wtake) begin
        r_full <= 1'b1;
        r_wdat <= wdat;
      end
      if (w_ack) begin
        r_addr <= r_addr + APP_AW'(BW);
        r_rem  <= r_rem - LEN_W'(1);
        r_full <= 1'b0;
        if (!r_we) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= wb_dat_o;
          r_rsp_last  <= w_last;
        end
        if (w_last) r_done <= 1'b1;
      end
      // Abort drops any held write beat
      if (w_expire) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
        r_full <= 1'b0;
      end
    end
  end

  assign wdat_ready = w_bus & r_we & ~r_full;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_last   = r_rsp_last;
  assign done       = r_done;
  assign err        = r_err;

  assign wb_cyc_i  = w_bus;
  assign wb_stb_i  = w_stb;
  assign wb_we_i   = w_bus & r_we;
  assign wb_addr_i = w_bus ? r_addr : '0;
  assign wb_dat_i  = (w_bus & r_we) ? r_wdat : '0;
  assign wb_sel_i  = w_bus ? r_sel : '0;
  assign wb_cti_i  = !w_bus   ? CTI_CLASSIC :
                     r_single ? CTI_CLASSIC :
                     w_last   ? CTI_END     : CTI_INCR;

endmodule

// File: tb/tb_wb_sdr_master.sv
// Bench for wb_sdr_master: vector table of commands, random commands,
// and a bus-level reference model with a randomized Wishbone slave.
module tb_wb_sdr_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdr_init_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [25:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        done;
  logic        err;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [25:0] wb_addr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  wb_sdr_master #(
    .dw      (32),
    .APP_AW  (26),
    .LEN_W   (4),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (sdr_init_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_sel       (cmd_sel),
    .wdat_valid    (wdat_valid),
    .wdat_ready    (wdat_ready),
    .wdat          (wdat),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .done          (done),
    .err           (err),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_addr_i     (wb_addr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_cti_i      (wb_cti_i),
    .wb_ack_o      (wb_ack_o),
    .wb_dat_o      (wb_dat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [25:0] addr;
    logic [3:0]  len;
    logic [3:0]  sel;
    int          ack_pct;
    int          gap;
    int          gap_beat;
    bit          noack;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_wb_zero(input string nm);
    chk({nm, " cyc"}, {31'd0, wb_cyc_i}, 0);
    chk({nm, " stb"}, {31'd0, wb_stb_i}, 0);
    chk({nm, " we"}, {31'd0, wb_we_i}, 0);
    chk({nm, " addr"}, {6'd0, wb_addr_i}, 0);
    chk({nm, " dat"}, wb_dat_i, 0);
    chk({nm, " sel"}, {28'd0, wb_sel_i}, 0);
    chk({nm, " cti"}, {29'd0, wb_cti_i}, 0);
  endtask

  // Drives one command and plays the slave; the model tracks beats,
  // expected address/cti, the held write beat and the ack watchdog.
  task automatic run_cmd(input vec_t c, output int beats,
                         output bit aerr);
    int          n;
    int          stbcnt;
    int          sent;
    int          gapcnt;
    bit          fin;
    bit          have;
    bit          ended;
    bit          rsp_pend;
    bit          rsp_plast;
    logic [31:0] rsp_exp;
    logic [31:0] wq;
    logic [25:0] base;
    logic [25:0] ea;
    logic [2:0]  ecti;
    n      = (c.len == 0) ? 1 : int'(c.len);
    base   = c.addr & ~26'h3;
    beats  = 0;
    aerr   = 1'b0;
    stbcnt = 0;
    sent   = 0;
    gapcnt = 0;
    fin    = 1'b0;
    have   = 1'b0;
    ended  = 1'b0;
    rsp_pend  = 1'b0;
    rsp_plast = 1'b0;
    rsp_exp   = '0;
    wq        = '0;
    chk("cmd_ready idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_we    = c.we;
    cmd_addr  = c.addr;
    cmd_len   = c.len;
    cmd_sel   = c.sel;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      cmd_valid  = 1'b0;
      wb_ack_o   = 1'b0;
      wdat_valid = 1'b0;
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_pend});
      if (rsp_pend) begin
        chk("rsp_data", rsp_data, rsp_exp);
        chk("rsp_last", {31'd0, rsp_last}, {31'd0, rsp_plast});
      end
      rsp_pend = 1'b0;
      if (fin || stbcnt == TMO) begin
        chk("done", {31'd0, done}, 1);
        chk("err", {31'd0, err}, {31'd0, !fin});
        chk("cyc end", {31'd0, wb_cyc_i}, 0);
        chk("cmd_ready end", {31'd0, cmd_ready}, 1);
        aerr  = !fin;
        ended = 1'b1;
        break;
      end
      chk("done low", {31'd0, done}, 0);
      chk("cyc", {31'd0, wb_cyc_i}, 1);
      chk("stb", {31'd0, wb_stb_i}, {31'd0, (c.we ? have : 1'b1)});
      chk("wdat_ready", {31'd0, wdat_ready},
          {31'd0, (c.we && !have)});
      if (wb_stb_i) begin
        ea   = base + 26'(beats * 4);
        ecti = (n == 1) ? 3'b000 : (beats == n - 1) ? 3'b111 : 3'b010;
        chk("addr", {6'd0, wb_addr_i}, {6'd0, ea});
        chk("cti", {29'd0, wb_cti_i}, {29'd0, ecti});
        chk("we", {31'd0, wb_we_i}, {31'd0, c.we});
        chk("sel", {28'd0, wb_sel_i}, {28'd0, c.sel});
        if (c.we) chk("wdat", wb_dat_i, wq);
        if (!c.noack && $urandom_range(0, 99) < c.ack_pct) begin
          wb_ack_o = 1'b1;
          wb_dat_o = $urandom;
          if (!c.we) begin
            rsp_pend  = 1'b1;
            rsp_exp   = wb_dat_o;
            rsp_plast = (beats == n - 1);
          end
          beats++;
          stbcnt = 0;
          have   = 1'b0;
          if (beats == n) fin = 1'b1;
        end else begin
          stbcnt++;
        end
      end else if (c.we) begin
        // Stray acks while stb is low must have no effect
        wb_ack_o = 1'($urandom_range(0, 1));
        wb_dat_o = $urandom;
        if (!have && sent < n) begin
          if (sent == c.gap_beat && gapcnt < c.gap) begin
            gapcnt++;
          end else begin
            wdat_valid = 1'b1;
            wdat       = $urandom;
            wq         = wdat;
            have       = 1'b1;
            sent++;
          end
        end
      end
    end
    if (!ended) chk("cycle bound", 0, 1);
    wb_ack_o   = 1'b0;
    wdat_valid = 1'b0;
  endtask

  vec_t vecs[9];
  vec_t v;
  int   got_beats;
  bit   got_err;

  initial begin
    vecs[0] = '{1'b0, 26'h100, 4'd4, 4'hF, 100, 0, 0, 1'b0, 4, 1'b0};
    vecs[1] = '{1'b1, 26'h200, 4'd3, 4'hA, 100, 5, 1, 1'b0, 3, 1'b0};
    vecs[2] = '{1'b0, 26'h40, 4'd0, 4'h3, 100, 0, 0, 1'b0, 1, 1'b0};
    vecs[3] = '{1'b0, 26'h3FFFFFC, 4'd2, 4'hF, 100, 0, 0, 1'b0, 2, 1'b0};
    vecs[4] = '{1'b0, 26'h10, 4'd3, 4'hF, 0, 0, 0, 1'b1, 0, 1'b1};
    vecs[5] = '{1'b1, 26'h7, 4'd1, 4'h5, 100, 0, 0, 1'b0, 1, 1'b0};
    vecs[6] = '{1'b1, 26'h300, 4'd2, 4'hC, 0, 0, 0, 1'b1, 0, 1'b1};
    vecs[7] = '{1'b0, 26'h1000, 4'd15, 4'hF, 100, 0, 0, 1'b0, 15, 1'b0};
    vecs[8] = '{1'b1, 26'h2000, 4'd6, 4'h9, 100, 2, 3, 1'b0, 6, 1'b0};

    rst           = 1'b1;
    sdr_init_done = 1'b0;
    cmd_valid     = 1'b0;
    cmd_we        = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    cmd_sel       = '0;
    wdat_valid    = 1'b0;
    wdat          = '0;
    wb_ack_o      = 1'b0;
    wb_dat_o      = '0;
    repeat (3) @(negedge clk);
    chk_wb_zero("reset");
    chk("reset cmd_ready", {31'd0, cmd_ready}, 0);
    chk("reset wdat_ready", {31'd0, wdat_ready}, 0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_last", {31'd0, rsp_last}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset err", {31'd0, err}, 0);
    rst = 1'b0;

    // Init gating with a command already pending
    cmd_valid = 1'b1;
    cmd_addr  = 26'h80;
    cmd_len   = 4'd1;
    cmd_sel   = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("init gate ready", {31'd0, cmd_ready}, 0);
      chk("init gate cyc", {31'd0, wb_cyc_i}, 0);
    end
    sdr_init_done = 1'b1;
    @(negedge clk);
    v = '{1'b0, 26'h80, 4'd1, 4'hF, 100, 0, 0, 1'b0, 1, 1'b0};
    run_cmd(v, got_beats, got_err);
    chk("init cmd beats", 32'(got_beats), 1);
    sdr_init_done = 1'b0;

    foreach (vecs[i]) begin
      run_cmd(vecs[i], got_beats, got_err);
      chk($sformatf("vec%0d beats", i), 32'(got_beats),
          32'(vecs[i].exp_beats));
      chk($sformatf("vec%0d err", i), {31'd0, got_err},
          {31'd0, vecs[i].exp_err});
    end

    for (int i = 0; i < 40; i++) begin
      v.we       = 1'($urandom_range(0, 1));
      v.addr     = 26'($urandom);
      v.len      = 4'($urandom_range(0, 15));
      v.sel      = 4'($urandom);
      v.ack_pct  = $urandom_range(40, 100);
      v.gap      = $urandom_range(0, 3);
      v.gap_beat = $urandom_range(0, 3);
      v.noack    = 1'b0;
      run_cmd(v, got_beats, got_err);
    end

    // Reset in the middle of a read burst
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 26'h500;
    cmd_len   = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    wb_ack_o  = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid-burst cyc", {31'd0, wb_cyc_i}, 1);
    wb_ack_o = 1'b0;
    rst      = 1'b1;
    #1;
    chk_wb_zero("async reset");
    chk("async reset ready", {31'd0, cmd_ready}, 0);
    chk("async reset done", {31'd0, done}, 0);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post-reset wait_init", {31'd0, cmd_ready}, 0);
      chk("post-reset cyc", {31'd0, wb_cyc_i}, 0);
    end
    cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sdr_master.md
# wb_sdr_master

Wishbone bus master placed directly upstream of the SDRAM controller's Wishbone slave port. It accepts simple read/write burst commands from a test or application stream, waits for SDRAM initialisation, and drives wb_cyc_i/wb_stb_i/wb_cti_i cycles with address auto-increment. Read data is returned on a response stream, and a per-beat ack timeout aborts a hung cycle.

## Interface
- dw, 32: Wishbone data width; byte lanes = dw/8.
- APP_AW, 26: Wishbone byte-address width.
- LEN_W, 4: width of the burst-length field; max burst 2**LEN_W-1 beats.
- TIMEOUT, 255: cycles with wb_stb_i high and no wb_ack_o before abort; must be ≥1.

- wb_clk_i  in  1  sole clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- sdr_init_done  in  1  SDRAM controller init complete.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  APP_AW  start byte address; low log2(dw/8) bits ignored, driven 0 on the bus.
- cmd_len  in  LEN_W  beat count; 0 is treated as 1.
- cmd_sel  in  dw/8  byte enables, applied to every beat.
- wdat_valid / wdat_ready  in / out  1 / 1  write-data handshake.
- wdat  in  dw  write beat data.
- rsp_valid  out  1  read beat valid; no backpressure.
- rsp_data  out  dw  read beat data.
- rsp_last  out  1  final read beat of a command.
- done  out  1  one-cycle pulse when a command completes or aborts.
- err  out  1  qualifies done; 1 = timeout abort.
- wb_cyc_i, wb_stb_i, wb_we_i  out  1 each  Wishbone control signals.
- wb_addr_i  out  APP_AW  Wishbone address.
- wb_dat_i  out  dw  Wishbone write data.
- wb_sel_i  out  dw/8  Wishbone byte enables.
- wb_cti_i  out  3  Wishbone cycle type identifier.
- wb_ack_o  in  1  Wishbone acknowledge.
- wb_dat_o  in  dw  Wishbone read data.

## Operation
- States: WAIT_INIT → IDLE → BUS → IDLE. Reset enters WAIT_INIT.
- WAIT_INIT: leave for IDLE on the first cycle sdr_init_done = 1. sdr_init_done is sampled only here; a later deassertion is ignored.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
  - latch we, aligned address, sel, and remaining = max(cmd_len, 1);
  - go to BUS and assert wb_cyc_i.
- BUS, read:
  - wb_stb_i = 1 for every beat.
  - Each ack: address += dw/8 (wraps modulo 2**APP_AW); remaining decrements.
  - Each ack: rsp_data ← wb_dat_o and rsp_valid = 1 on the next cycle.
- BUS, write:
  - A one-entry beat register holds the data; wdat_ready = ~full.
  - wb_stb_i = full.
  - An ack empties the register and advances address and remaining.
  - wb_cyc_i stays high through data starvation, so stb-low wait states are legal.
- wb_cti_i:
  - 3'b000 for a 1-beat command;
  - otherwise 3'b010 while remaining > 1, and 3'b111 on the last beat.
- Completion: on the ack with remaining = 1, go to IDLE, pulse done with err = 0, and assert rsp_last with the last read beat.
- Timeout:
  - The counter resets on every ack and on entry to BUS, and counts while wb_stb_i = 1.
  - On reaching TIMEOUT: drop cyc/stb, go to IDLE, pulse done with err = 1.
  - No further rsp beats are issued. Write data still held in the register is discarded.
- A wb_ack_o received while wb_stb_i = 0 is ignored.

## Timing
- Reset values: every output is 0 (including cmd_ready, wdat_ready, rsp_*, done, err, all wb_*), and the state is WAIT_INIT.
- Wishbone outputs are cleared asynchronously on wb_rst_i, including mid-burst.
- Read accepted at cycle N: wb_cyc_i = wb_stb_i = 1 at N+1.
- Ack at cycle M: rsp_valid = 1 at M+1; the next beat's wb_addr_i is valid at M+1.
- Last ack at cycle M: cyc/stb = 0, done = 1, and cmd_ready = 1 all at M+1. The next command is accepted at M+1 at the earliest, and its bus cycle starts at M+2.
- Write: wdat accepted at cycle K gives wb_stb_i = 1 at K+1. This costs a one-cycle bubble per beat; single-cycle back-to-back beats are not required.
- Timeout with stb rising at cycle S and no ack: abort is visible (cyc = 0, done = err = 1) at S+TIMEOUT.

## Structure
- Package sdr_wb_pkg holds:
  - CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_END = 3'b111;
  - the state enum wbm_state_t {WAIT_INIT, IDLE, BUS}.
- Sub-module wb_ack_timeout (parameter TIMEOUT):
  - inputs wb_clk_i, wb_rst_i, run, clr;
  - output expire (a one-cycle pulse).
- Everything else lives in the top module.

## Test plan
- Init gating: sdr_init_done held 0 for 20 cycles with cmd_valid = 1 → cmd_ready stays 0. Raise it → command accepted on the next cycle.
- Read burst, cmd_addr = 0x100, cmd_len = 4, slave acks every cycle:
  - addresses 0x100, 0x104, 0x108, 0x10C;
  - cti 010, 010, 010, 111;
  - 4 rsp_valid pulses, rsp_last on the 4th, done with err = 0.
- Write with starvation, cmd_len = 3, wdat gap of 5 cycles before beat 2 → wb_cyc_i stays 1, wb_stb_i = 0 during the gap, data/sel exact on each ack.
- Single beat, cmd_len = 0 → exactly one beat with cti = 000.
- Address wrap, cmd_addr = 0x3FFFFFC, cmd_len = 2 → second address is 0x0000000.
- Timeout and reset:
  - TIMEOUT = 8, no ack → abort at S+8 with done = err = 1, then a clean next command.
  - Separately, wb_rst_i asserted mid-burst → all wb_* outputs 0 immediately, state WAIT_INIT.
